// File: rtl/rv32i_types.sv
// Shared RV32I load/store types for the MEM-stage LSU: width/sign encodings,
// FSM states, and the byte-lane helpers used by the top level.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } mem_funct3_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_WAIT = 2'd1,
    DONE     = 2'd2
  } lsu_state_t;

  // funct3[1:0] encodes access size; the sign bit (funct3[2]) does not affect lanes.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] a_lo);
    case (funct3[1:0])
      2'b00:   byte_mask = 4'b0001 << a_lo;
      2'b01:   byte_mask = 4'b0011 << a_lo;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] a_lo);
    case (funct3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a_lo[0];
      default: is_misaligned = (a_lo != 2'b00);
    endcase
  endfunction

  function automatic logic [1:0] force_align(input logic [2:0] funct3, input logic [1:0] a_lo);
    case (funct3[1:0])
      2'b00:   force_align = a_lo;
      2'b01:   force_align = {a_lo[1], 1'b0};
      default: force_align = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface mem_lsu_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_rmask;
  logic [3:0]      dmem_wmask;
  logic [31:0]     dmem_wdata;
  logic [31:0]     dmem_rdata;
  logic            dmem_resp;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/load_align.sv
// Combinational load extractor: moves the addressed byte/half to bit 0 and
// sign- or zero-extends it according to funct3.
module load_align
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      a_lo,
  output logic [XLEN-1:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {a_lo, 3'b000};

  // NOTE: every path of an always_comb must assign its outputs; the default
  // first line guarantees that, so no latch is inferred for unlisted funct3.
  always_comb begin
    data = '0;
    case (funct3)
      F3_B: begin
        data       = {XLEN{shifted[7]}};
        data[7:0]  = shifted[7:0];
      end
      F3_H: begin
        data       = {XLEN{shifted[15]}};
        data[15:0] = shifted[15:0];
      end
      F3_BU:   data[7:0]  = shifted[7:0];
      F3_HU:   data[15:0] = shifted[15:0];
      default: data[31:0] = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues dmem requests, waits for the response,
// forwards rd to EX and hands results to WB. Optional LSU_MISALIGN_TRAP_EN adds misalign_trap.
module mem_lsu
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [4:0]      in_rd_addr,
  output logic            in_ready,
  mem_lsu_if.master       dmem,
  output logic [4:0]      rd_addr_mem,
  output logic [XLEN-1:0] rd_data_mem,
  output logic            load_pending,
  input  logic            wb_stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_rd_data
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap
`endif
);

  lsu_state_t      state;
  logic            is_load_q;
  logic [2:0]      funct3_q;
  logic [1:0]      a_lo_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] result_q;

  logic            is_store;
  logic            is_mem;
  logic            misalign;
  logic            issue;
  logic [1:0]      a_lo;
  logic [3:0]      mask;
  logic [XLEN-1:0] load_data;

  assign is_store = in_is_store & ~in_is_load;
  assign is_mem   = in_is_load | in_is_store;

`ifdef LSU_MISALIGN_TRAP_EN
  assign a_lo     = in_addr[1:0];
  assign misalign = is_mem & is_misaligned(in_funct3, in_addr[1:0]);
`else
  // Without the trap, misaligned halves/words silently drop their low bits.
  assign a_lo     = force_align(in_funct3, in_addr[1:0]);
  assign misalign = 1'b0;
`endif

  // Request is driven combinationally in the accept cycle so memory sees it one cycle earlier.
  assign issue = (state == IDLE) & in_valid & is_mem & ~misalign;
  assign mask  = byte_mask(in_funct3, a_lo);

  assign dmem.dmem_addr  = issue ? {in_addr[XLEN-1:2], 2'b00} : '0;
  assign dmem.dmem_rmask = (issue & in_is_load) ? mask : 4'b0000;
  assign dmem.dmem_wmask = (issue & is_store) ? mask : 4'b0000;
  assign dmem.dmem_wdata = (issue & is_store) ? (in_store_data[31:0] << {a_lo, 3'b000}) : 32'h0;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem.dmem_rdata),
    .funct3 (funct3_q),
    .a_lo   (a_lo_q),
    .data   (load_data)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      is_load_q <= 1'b0;
      funct3_q  <= 3'b000;
      a_lo_q    <= 2'b00;
      rd_q      <= 5'd0;
      result_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            is_load_q <= in_is_load & ~misalign;
            funct3_q  <= in_funct3;
            a_lo_q    <= a_lo;
            rd_q      <= (is_store | misalign) ? 5'd0 : in_rd_addr;
            result_q  <= (in_is_load | misalign) ? '0 : in_alu_result;
            state     <= issue ? REQ_WAIT : DONE;
          end
        end
        REQ_WAIT: begin
          if (dmem.dmem_resp) begin
            if (is_load_q) result_q <= load_data;
            state <= DONE;
          end
        end
        DONE: begin
          if (!wb_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 misalign_trap <= 1'b0;
    else if (state == IDLE && in_valid)      misalign_trap <= misalign;
    else if (state == DONE && !wb_stall)     misalign_trap <= 1'b0;
  end
`endif

  assign in_ready     = (state == IDLE);
  assign rd_addr_mem  = (state != IDLE) ? rd_q : 5'd0;
  assign rd_data_mem  = (state != IDLE) ? result_q : '0;
  assign load_pending = (state == REQ_WAIT) & is_load_q;
  assign wb_valid     = (state == DONE);
  assign wb_rd_addr   = wb_valid ? rd_q : 5'd0;
  assign wb_rd_data   = wb_valid ? result_q : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus randomized ops
// compared against a byte-arithmetic reference model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_alu_result, in_store_data;
  logic [4:0]  in_rd_addr;
  logic        in_ready;
  logic [4:0]  rd_addr_mem;
  logic [31:0] rd_data_mem;
  logic        load_pending;
  logic        wb_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mem_lsu_if #(.XLEN(32)) dmem_bus ();

  mem_lsu #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_funct3     (in_funct3),
    .in_addr       (in_addr),
    .in_alu_result (in_alu_result),
    .in_store_data (in_store_data),
    .in_rd_addr    (in_rd_addr),
    .in_ready      (in_ready),
    .dmem          (dmem_bus),
    .rd_addr_mem   (rd_addr_mem),
    .rd_data_mem   (rd_data_mem),
    .load_pending  (load_pending),
    .wb_stall      (wb_stall),
    .wb_valid      (wb_valid),
    .wb_rd_addr    (wb_rd_addr),
    .wb_rd_data    (wb_rd_data)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_trap (misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rmask, wmask;
    logic [31:0] addr, wdata;
    int          mask_cycles, pend_cycles, wb_cycles, latency, busy_ready;
    logic [4:0]  wb_rd, fwd_rd;
    logic [31:0] wb_data, fwd_data;
    bit          unstable, trap, timeout;
  } obs_t;

  typedef struct {
    logic [3:0]  rmask, wmask;
    logic [31:0] addr, wdata, wb_data;
    logic [4:0]  wb_rd;
    bit          mem, trap;
  } exp_t;

  // Reference: sizes in bytes, lanes and extension from plain arithmetic.
  function automatic exp_t ref_op(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] alu,
                                  input logic [31:0] sdata, input logic [31:0] rdata,
                                  input logic [4:0] rd);
    exp_t e;
    int size, a;
    logic [3:0]  m;
    logic [31:0] v;
    bit mis;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    a    = int'(addr[1:0]);
    mis  = (ld || st) && (a % size != 0);
    e.trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    e.trap = mis;
`else
    if (mis) a = a - (a % size);
`endif
    e.mem  = (ld || st) && !e.trap;
    e.addr = e.mem ? (addr & 32'hFFFF_FFFC) : 32'h0;
    m = 4'((1 << size) - 1);
    m = m << a;
    e.rmask = (e.mem && ld) ? m : 4'b0000;
    e.wmask = (e.mem && st && !ld) ? m : 4'b0000;
    e.wdata = (e.mem && st && !ld) ? (sdata << (8 * a)) : 32'h0;
    if (e.trap) begin
      e.wb_rd = 5'd0; e.wb_data = 32'h0;
    end else if (ld) begin
      v = rdata >> (8 * a);
      if (size == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      e.wb_rd = rd; e.wb_data = v;
    end else begin
      e.wb_rd = st ? 5'd0 : rd; e.wb_data = alu;
    end
    return e;
  endfunction

  // Drives one instruction through the stage and records what the DUT did.
  task automatic issue_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] alu,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input logic [4:0] rd, input int delay, input int stall,
                          input bit stale, output obs_t o);
    int  cyc;
    int  stalls_left;
    bit  done;
    o = '{default: 0};
    in_is_load = ld; in_is_store = st; in_funct3 = f3; in_addr = addr;
    in_alu_result = alu; in_store_data = sdata; in_rd_addr = rd;
    cyc = 0; done = 1'b0; stalls_left = stall;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      in_valid = (cyc == 0);
      dmem_bus.dmem_resp  = 1'b0;
      dmem_bus.dmem_rdata = $urandom;
      if ((ld || st) && cyc == delay) begin
        dmem_bus.dmem_resp = 1'b1; dmem_bus.dmem_rdata = rdata;
      end
      if (stale && o.wb_cycles > 0) dmem_bus.dmem_resp = 1'b1;
      wb_stall = (stalls_left > 0);
      @(negedge clk);
      if (dmem_bus.dmem_rmask != 4'b0 || dmem_bus.dmem_wmask != 4'b0) o.mask_cycles++;
      if (cyc == 0) begin
        o.rmask = dmem_bus.dmem_rmask; o.wmask = dmem_bus.dmem_wmask;
        o.addr  = dmem_bus.dmem_addr;  o.wdata = dmem_bus.dmem_wdata;
      end
      if (cyc == 1) o.fwd_rd = rd_addr_mem;
      if (load_pending) o.pend_cycles++;
      if (cyc > 0 && in_ready) o.busy_ready++;
      if (wb_valid) begin
        if (o.wb_cycles == 0) begin
          o.latency = cyc; o.wb_rd = wb_rd_addr; o.wb_data = wb_rd_data; o.fwd_data = rd_data_mem;
`ifdef LSU_MISALIGN_TRAP_EN
          o.trap = misalign_trap;
`endif
        end else if (wb_rd_addr !== o.wb_rd || wb_rd_data !== o.wb_data) begin
          o.unstable = 1'b1;
        end
        o.wb_cycles++;
        if (wb_stall) stalls_left--;
        else done = 1'b1;
      end
      cyc++;
    end
    in_valid = 1'b0; dmem_bus.dmem_resp = 1'b0; wb_stall = 1'b0;
    o.timeout = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if ({dmem_bus.dmem_addr, dmem_bus.dmem_rmask, dmem_bus.dmem_wmask, dmem_bus.dmem_wdata, rd_addr_mem,
                    rd_data_mem, load_pending, wb_valid, wb_rd_addr, wb_rd_data} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs want all zero");
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    obs_t o;
    issue_op(1, 0, 3'b010, 32'h100, 32'h55, 32'h0, 32'hDEADBEEF, 5'd3, 3, 0, 0, o);
    n_tests++; if (o.timeout)              begin n_fail++; $display("FAIL lw_timeout: no wb_valid within bound"); end
    n_tests++; if (o.rmask !== 4'b1111)    begin n_fail++; $display("FAIL lw_rmask: got %b want 1111", o.rmask); end
    n_tests++; if (o.addr !== 32'h100)     begin n_fail++; $display("FAIL lw_addr: got %h want 00000100", o.addr); end
    n_tests++; if (o.mask_cycles != 1)     begin n_fail++; $display("FAIL lw_mask_cycles: got %0d want 1", o.mask_cycles); end
    n_tests++; if (o.pend_cycles != 3)     begin n_fail++; $display("FAIL lw_pending: got %0d want 3", o.pend_cycles); end
    n_tests++; if (o.latency != 4)         begin n_fail++; $display("FAIL lw_latency: got %0d want 4", o.latency); end
    n_tests++; if (o.wb_data !== 32'hDEADBEEF || o.wb_rd !== 5'd3) begin
      n_fail++; $display("FAIL lw_wb: got rd=%0d data=%h want rd=3 data=deadbeef", o.wb_rd, o.wb_data);
    end
  endtask

  task automatic test_lb_lbu();
    obs_t o;
    issue_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h0, 32'h80FFFFFF, 5'd7, 1, 0, 0, o);
    n_tests++; if (o.rmask !== 4'b1000)      begin n_fail++; $display("FAIL lb_rmask: got %b want 1000", o.rmask); end
    n_tests++; if (o.wb_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", o.wb_data); end
    issue_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h0, 32'h80FFFFFF, 5'd7, 2, 0, 0, o);
    n_tests++; if (o.rmask !== 4'b1000)      begin n_fail++; $display("FAIL lbu_rmask: got %b want 1000", o.rmask); end
    n_tests++; if (o.wb_data !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h want 00000080", o.wb_data); end
  endtask

  task automatic test_sh();
    obs_t o;
    issue_op(0, 1, 3'b001, 32'h202, 32'h202, 32'h1234ABCD, 32'h0, 5'd9, 2, 0, 0, o);
    n_tests++; if (o.wmask !== 4'b1100)      begin n_fail++; $display("FAIL sh_wmask: got %b want 1100", o.wmask); end
    n_tests++; if (o.rmask !== 4'b0000)      begin n_fail++; $display("FAIL sh_rmask: got %b want 0000", o.rmask); end
    n_tests++; if (o.wdata !== 32'hABCD0000) begin n_fail++; $display("FAIL sh_wdata: got %h want abcd0000", o.wdata); end
    n_tests++; if (o.fwd_rd !== 5'd0)        begin n_fail++; $display("FAIL sh_rd_addr_mem: got %0d want 0", o.fwd_rd); end
    n_tests++; if (o.wb_cycles != 1 || o.wb_rd !== 5'd0) begin
      n_fail++; $display("FAIL sh_wb: got cycles=%0d rd=%0d want cycles=1 rd=0", o.wb_cycles, o.wb_rd);
    end
  endtask

  task automatic test_alu_stall();
    obs_t o;
    issue_op(0, 0, 3'b000, 32'h7, 32'h7, 32'h0, 32'h0, 5'd5, 1, 2, 0, o);
    n_tests++; if (o.latency != 1)       begin n_fail++; $display("FAIL alu_latency: got %0d want 1", o.latency); end
    n_tests++; if (o.fwd_rd !== 5'd5 || o.fwd_data !== 32'd7) begin
      n_fail++; $display("FAIL alu_forward: got rd=%0d data=%h want rd=5 data=00000007", o.fwd_rd, o.fwd_data);
    end
    n_tests++; if (o.wb_cycles != 3)     begin n_fail++; $display("FAIL alu_wb_cycles: got %0d want 3", o.wb_cycles); end
    n_tests++; if (o.unstable)           begin n_fail++; $display("FAIL alu_hold: got changing wb outputs want stable"); end
    n_tests++; if (o.busy_ready != 0)    begin n_fail++; $display("FAIL alu_in_ready: got %0d ready cycles want 0", o.busy_ready); end
    n_tests++; if (o.mask_cycles != 0)   begin n_fail++; $display("FAIL alu_masks: got %0d mask cycles want 0", o.mask_cycles); end
  endtask

  task automatic test_misalign();
    obs_t o;
    issue_op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 32'h11223344, 5'd4, 2, 0, 0, o);
`ifdef LSU_MISALIGN_TRAP_EN
    n_tests++; if (o.trap !== 1'b1)      begin n_fail++; $display("FAIL mis_trap: got %b want 1", o.trap); end
    n_tests++; if (o.mask_cycles != 0)   begin n_fail++; $display("FAIL mis_masks: got %0d mask cycles want 0", o.mask_cycles); end
    n_tests++; if (o.wb_rd !== 5'd0)     begin n_fail++; $display("FAIL mis_wb_rd: got %0d want 0", o.wb_rd); end
`else
    n_tests++; if (o.rmask !== 4'b1111)  begin n_fail++; $display("FAIL mis_rmask: got %b want 1111", o.rmask); end
    n_tests++; if (o.addr !== 32'h100)   begin n_fail++; $display("FAIL mis_addr: got %h want 00000100", o.addr); end
    n_tests++; if (o.wb_data !== 32'h11223344) begin n_fail++; $display("FAIL mis_data: got %h want 11223344", o.wb_data); end
`endif
  endtask

  task automatic test_resp_with_stall();
    obs_t o;
    issue_op(1, 0, 3'b001, 32'h106, 32'h0, 32'h0, 32'h9ABC0000, 5'd12, 2, 2, 1, o);
    n_tests++; if (o.wb_data !== 32'hFFFF9ABC) begin n_fail++; $display("FAIL rs_data: got %h want ffff9abc", o.wb_data); end
    n_tests++; if (o.latency != 3)       begin n_fail++; $display("FAIL rs_latency: got %0d want 3", o.latency); end
    n_tests++; if (o.wb_cycles != 3)     begin n_fail++; $display("FAIL rs_wb_cycles: got %0d want 3", o.wb_cycles); end
    n_tests++; if (o.unstable)           begin n_fail++; $display("FAIL rs_hold: got changing wb outputs with stale resp want stable"); end
  endtask

  task automatic test_reset_mid_request();
    obs_t o;
    in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h400; in_rd_addr = 5'd6;
    @(posedge clk); #1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (load_pending !== 1'b1) begin n_fail++; $display("FAIL rm_pending_before: got %b want 1", load_pending); end
    #2; rst = 1'b1; #1;
    n_tests++; if ({dmem_bus.dmem_addr, dmem_bus.dmem_rmask, dmem_bus.dmem_wmask, dmem_bus.dmem_wdata, rd_addr_mem,
                    rd_data_mem, load_pending, wb_valid, wb_rd_addr, wb_rd_data} !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rm_reset_outputs: got nonzero outputs or in_ready=%b want zeros and ready", in_ready);
    end
    @(posedge clk); #1; rst = 1'b0;
    dmem_bus.dmem_resp = 1'b1; dmem_bus.dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    @(posedge clk); #1; dmem_bus.dmem_resp = 1'b0;
    @(negedge clk);
    n_tests++; if (wb_valid !== 1'b0 || in_ready !== 1'b1 || rd_addr_mem !== 5'd0) begin
      n_fail++; $display("FAIL rm_late_resp: got wb_valid=%b in_ready=%b rd=%0d want 0 1 0", wb_valid, in_ready, rd_addr_mem);
    end
    issue_op(1, 0, 3'b010, 32'h500, 32'h0, 32'h0, 32'h01020304, 5'd8, 1, 0, 0, o);
    n_tests++; if (o.rmask !== 4'b1111 || o.addr !== 32'h500) begin
      n_fail++; $display("FAIL rm_reissue_req: got mask=%b addr=%h want 1111 00000500", o.rmask, o.addr);
    end
    n_tests++; if (o.wb_data !== 32'h01020304 || o.wb_rd !== 5'd8) begin
      n_fail++; $display("FAIL rm_reissue_wb: got rd=%0d data=%h want rd=8 data=01020304", o.wb_rd, o.wb_data);
    end
  endtask

  task automatic test_random(input int n);
    obs_t o;
    exp_t e;
    bit ld, st;
    logic [2:0] f3;
    logic [31:0] addr, alu, sdata, rdata;
    logic [4:0] rd;
    int kind, delay, stall;
    bit stale;
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 8));
      ld = (kind <= 4); st = (kind >= 5 && kind <= 7);
      case (kind)
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; 4: f3 = 3'b101;
        5: f3 = 3'b000; 6: f3 = 3'b001; 7: f3 = 3'b010;
        default: f3 = 3'($urandom);
      endcase
      addr = $urandom; alu = $urandom; sdata = $urandom; rdata = $urandom;
      rd = 5'($urandom_range(0, 31));
      delay = int'($urandom_range(1, 4)); stall = int'($urandom_range(0, 2)); stale = 1'($urandom_range(0, 1));
      e = ref_op(ld, st, f3, addr, alu, sdata, rdata, rd);
      issue_op(ld, st, f3, addr, alu, sdata, rdata, rd, delay, stall, stale, o);
      n_tests++; if (o.timeout) begin n_fail++; $display("FAIL rnd%0d_timeout: no wb_valid within bound", i); end
      n_tests++; if (o.rmask !== e.rmask || o.wmask !== e.wmask) begin
        n_fail++; $display("FAIL rnd%0d_masks: got r=%b w=%b want r=%b w=%b", i, o.rmask, o.wmask, e.rmask, e.wmask);
      end
      n_tests++; if (o.addr !== e.addr || o.wdata !== e.wdata) begin
        n_fail++; $display("FAIL rnd%0d_req: got a=%h d=%h want a=%h d=%h", i, o.addr, o.wdata, e.addr, e.wdata);
      end
      n_tests++; if (o.mask_cycles != (e.mem ? 1 : 0)) begin
        n_fail++; $display("FAIL rnd%0d_mask_cycles: got %0d want %0d", i, o.mask_cycles, e.mem ? 1 : 0);
      end
      n_tests++; if (o.pend_cycles != ((e.mem && ld) ? delay : 0)) begin
        n_fail++; $display("FAIL rnd%0d_pending: got %0d want %0d", i, o.pend_cycles, (e.mem && ld) ? delay : 0);
      end
      n_tests++; if (o.latency != (e.mem ? delay + 1 : 1)) begin
        n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, o.latency, e.mem ? delay + 1 : 1);
      end
      n_tests++; if (o.wb_rd !== e.wb_rd || o.fwd_rd !== e.wb_rd) begin
        n_fail++; $display("FAIL rnd%0d_rd: got wb=%0d fwd=%0d want %0d", i, o.wb_rd, o.fwd_rd, e.wb_rd);
      end
      if (!e.trap) begin
        n_tests++; if (o.wb_data !== e.wb_data || o.fwd_data !== e.wb_data) begin
          n_fail++; $display("FAIL rnd%0d_data: got wb=%h fwd=%h want %h", i, o.wb_data, o.fwd_data, e.wb_data);
        end
      end
      n_tests++; if (o.wb_cycles != stall + 1 || o.unstable) begin
        n_fail++; $display("FAIL rnd%0d_wb_hold: got cycles=%0d unstable=%b want %0d stable", i, o.wb_cycles, o.unstable, stall + 1);
      end
      n_tests++; if (o.busy_ready != 0) begin n_fail++; $display("FAIL rnd%0d_in_ready: got %0d busy-ready cycles want 0", i, o.busy_ready); end
`ifdef LSU_MISALIGN_TRAP_EN
      n_tests++; if (o.trap !== e.trap) begin n_fail++; $display("FAIL rnd%0d_trap: got %b want %b", i, o.trap, e.trap); end
`endif
    end
  endtask

  initial begin
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b000;
    in_addr = '0; in_alu_result = '0; in_store_data = '0; in_rd_addr = '0;
    wb_stall = 1'b0; dmem_bus.dmem_resp = 1'b0; dmem_bus.dmem_rdata = '0;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_alu_stall();
    test_misalign();
    test_resp_with_stall();
    test_reset_mid_request();
    test_random(60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
